// File: rtl/mips_pkg.sv
// mips_pkg: constants shared by the MIPS front end.
//   - INSTR_W and the opcode values the decode-stage control unit matches on.
//   - Encoding of the fetch state machine (IDLE, REQ, WAIT, HOLD, DROP).
//   - Field-extraction helpers for the Op and Funct fields.
package mips_pkg;

  localparam int unsigned INSTR_W  = 32;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned FSTATE_W = 3;

  // Opcodes consumed by the decode-stage control unit
  localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
  localparam logic [OP_W-1:0] OP_SUBI = 6'b001001;
  localparam logic [OP_W-1:0] OP_BEQZ = 6'b000100;
  localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW   = 6'b101011;

  // Fetch state encoding
  localparam logic [FSTATE_W-1:0] FS_IDLE = 3'd0;
  localparam logic [FSTATE_W-1:0] FS_REQ  = 3'd1;
  localparam logic [FSTATE_W-1:0] FS_WAIT = 3'd2;
  localparam logic [FSTATE_W-1:0] FS_HOLD = 3'd3;
  localparam logic [FSTATE_W-1:0] FS_DROP = 3'd4;

  function automatic logic [OP_W-1:0] instr_op(input logic [INSTR_W-1:0] instr);
    return instr[31:26];
  endfunction

  function automatic logic [OP_W-1:0] instr_funct(input logic [INSTR_W-1:0] instr);
    return instr[5:0];
  endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// fetch_hold_buf: one-entry skid buffer for a fetched word that arrives while
// decode is stalled.
//   clk, rst_n     clock, asynchronous active-low reset
//   load           capture word_i / pcp4_i and mark full
//   drain          entry consumed by IF/ID; mark empty
//   clear          discard the entry (redirect); mark empty
//   word_i, pcp4_i incoming instruction word and its fetch address + 4
//   full           entry holds a word
//   word, pcp4     stored word and its fetch address + 4
module fetch_hold_buf
  import mips_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               load,
  input  logic               drain,
  input  logic               clear,
  input  logic [INSTR_W-1:0] word_i,
  input  logic [ADDR_W-1:0]  pcp4_i,
  output logic               full,
  output logic [INSTR_W-1:0] word,
  output logic [ADDR_W-1:0]  pcp4
);

  logic               full_q, full_d;
  logic [INSTR_W-1:0] word_q, word_d;
  logic [ADDR_W-1:0]  pcp4_q, pcp4_d;

  // Next entry: clear/drain empty it, load fills it
  always_comb begin
    full_d = full_q;
    word_d = word_q;
    pcp4_d = pcp4_q;
    if (clear || drain) begin
      full_d = 1'b0;
    end else if (load) begin
      full_d = 1'b1;
      word_d = word_i;
      pcp4_d = pcp4_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      word_q <= '0;
      pcp4_q <= '0;
    end else begin
      full_q <= full_d;
      word_q <= word_d;
      pcp4_q <= pcp4_d;
    end
  end

  assign full = full_q;
  assign word = word_q;
  assign pcp4 = pcp4_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: MIPS instruction-fetch stage plus IF/ID register.
// Issues one request at a time to a variable-latency instruction memory,
// honours decode stalls and branch redirects (no delay slot).
//   clk, rst_n            clock, asynchronous active-low reset
//   StallD                hold IF/ID, do not advance the PC
//   PCSrcD, PCBranchD     decode-stage redirect and its target
//   IMemReq, IMemAddr     registered single-cycle request and its address
//   IMemValid, IMemRdata  memory response strobe and instruction word
//   InstrD, PCPlus4D      IF/ID instruction and its fetch address + 4
//   OpD, FunctD           combinational Op/Funct slices of InstrD
//   ValidD                InstrD holds a real instruction (0 = bubble)
//   FetchStallCnt         cycles in WAIT/HOLD/DROP, saturating; only when
//                         IFETCH_PERF_EN is defined
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               StallD,
  input  logic               PCSrcD,
  input  logic [ADDR_W-1:0]  PCBranchD,
  output logic               IMemReq,
  output logic [ADDR_W-1:0]  IMemAddr,
  input  logic               IMemValid,
  input  logic [INSTR_W-1:0] IMemRdata,
  output logic [INSTR_W-1:0] InstrD,
  output logic [OP_W-1:0]    OpD,
  output logic [OP_W-1:0]    FunctD,
  output logic [ADDR_W-1:0]  PCPlus4D,
  output logic               ValidD
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]        FetchStallCnt
`endif
);

  logic [FSTATE_W-1:0] state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic                imem_req_q, imem_req_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [ADDR_W-1:0]   pcp4_q, pcp4_d;
  logic                valid_q, valid_d;

  logic [ADDR_W-1:0]   pc_plus4;
  logic                hb_load, hb_drain, hb_clear, hb_full;
  logic [INSTR_W-1:0]  hb_word;
  logic [ADDR_W-1:0]   hb_pcp4;

  // Wraps modulo 2^ADDR_W
  assign pc_plus4 = pc_q + ADDR_W'(4);

  fetch_hold_buf #(
    .ADDR_W (ADDR_W)
  ) u_hold_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (hb_load),
    .drain  (hb_drain),
    .clear  (hb_clear),
    .word_i (IMemRdata),
    .pcp4_i (pc_plus4),
    .full   (hb_full),
    .word   (hb_word),
    .pcp4   (hb_pcp4)
  );

  // Next-state, PC and IF/ID update
  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pcp4_d   = pcp4_q;
    // IF/ID holds under stall, otherwise becomes a bubble unless loaded below
    valid_d  = StallD ? valid_q : 1'b0;
    hb_load  = 1'b0;
    hb_drain = 1'b0;
    hb_clear = 1'b0;

    case (state_q)
      FS_IDLE: state_d = FS_REQ;  // IMemValid ignored: flushes pre-reset responses
      FS_REQ:  state_d = FS_WAIT;
      FS_WAIT: begin
        if (IMemValid) begin
          pc_d = pc_plus4;
          if (!StallD) begin
            instr_d = IMemRdata;
            pcp4_d  = pc_plus4;
            valid_d = 1'b1;
            state_d = FS_REQ;
          end else begin
            hb_load = 1'b1;
            state_d = FS_HOLD;
          end
        end
      end
      FS_HOLD: begin
        if (!StallD) begin
          instr_d  = hb_word;
          pcp4_d   = hb_pcp4;
          valid_d  = hb_full;
          hb_drain = 1'b1;
          state_d  = FS_REQ;
        end
      end
      FS_DROP: begin
        if (IMemValid) state_d = FS_REQ;
      end
      default: state_d = FS_IDLE;
    endcase

    // Redirect wins over stall and over an arriving response
    if (PCSrcD) begin
      pc_d     = PCBranchD & ~ADDR_W'(3);
      instr_d  = instr_q;
      pcp4_d   = pcp4_q;
      valid_d  = 1'b0;
      hb_load  = 1'b0;
      hb_drain = 1'b0;
      case (state_q)
        FS_REQ:  state_d = FS_DROP;
        FS_WAIT: state_d = IMemValid ? FS_REQ : FS_DROP;
        FS_HOLD: begin
          hb_clear = 1'b1;
          state_d  = FS_REQ;
        end
        // IDLE/DROP: redirect only moves the PC; the pending drop still completes
        default: ;
      endcase
    end

    // Request is issued from the cycle spent in REQ, addressed by the new PC
    imem_req_d  = (state_d == FS_REQ);
    imem_addr_d = (state_d == FS_REQ) ? pc_d : imem_addr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FS_IDLE;
      pc_q        <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
      instr_q     <= '0;
      pcp4_q      <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      instr_q     <= instr_d;
      pcp4_q      <= pcp4_d;
      valid_q     <= valid_d;
    end
  end

  assign IMemReq  = imem_req_q;
  assign IMemAddr = imem_addr_q;
  assign InstrD   = instr_q;
  assign PCPlus4D = pcp4_q;
  assign ValidD   = valid_q;
  assign OpD      = instr_op(instr_q);
  assign FunctD   = instr_funct(instr_q);

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_cnt_q, perf_cnt_d;
  logic        perf_stall;

  // Saturating count of cycles waiting on memory or decode
  always_comb begin
    perf_stall = (state_q == FS_WAIT) || (state_q == FS_HOLD) || (state_q == FS_DROP);
    perf_cnt_d = perf_cnt_q;
    if (perf_stall && (perf_cnt_q != 32'hFFFF_FFFF)) perf_cnt_d = perf_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_cnt_q <= '0;
    else        perf_cnt_q <= perf_cnt_d;
  end

  assign FetchStallCnt = perf_cnt_q;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed testbench for instr_fetch_unit with a variable-latency memory
// responder. Inputs are driven and outputs sampled on the falling edge.
module tb_instr_fetch_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        StallD, PCSrcD;
  logic [31:0] PCBranchD;
  logic        IMemReq;
  logic [31:0] IMemAddr;
  logic        IMemValid;
  logic [31:0] IMemRdata;
  logic [31:0] InstrD;
  logic [5:0]  OpD, FunctD;
  logic [31:0] PCPlus4D;
  logic        ValidD;
`ifdef IFETCH_PERF_EN
  logic [31:0] FetchStallCnt;
`endif

  instr_fetch_unit #(.ADDR_W(32), .RESET_PC(32'h0)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .StallD    (StallD),
    .PCSrcD    (PCSrcD),
    .PCBranchD (PCBranchD),
    .IMemReq   (IMemReq),
    .IMemAddr  (IMemAddr),
    .IMemValid (IMemValid),
    .IMemRdata (IMemRdata),
    .InstrD    (InstrD),
    .OpD       (OpD),
    .FunctD    (FunctD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
`ifdef IFETCH_PERF_EN
    ,
    .FetchStallCnt (FetchStallCnt)
`endif
  );

  always #5 clk = ~clk;

  // Memory model: 64 words indexed by addr[7:2]
  logic [31:0] mem [64];
  logic        mem_valid   = 1'b0;
  logic        extra_valid = 1'b0;
  logic        mem_pending = 1'b0;
  int          mem_cnt     = 0;
  int          lat         = 1;
  logic [31:0] mem_addr    = '0;
  logic [31:0] mem_rdata   = '0;

  assign IMemValid = mem_valid | extra_valid;
  assign IMemRdata = mem_rdata;

  // Response arrives 'lat' cycles after the cycle the request is seen in
  always @(negedge clk) begin
    mem_valid = 1'b0;
    if (mem_pending) begin
      if (mem_cnt == 1) begin
        mem_valid   = 1'b1;
        mem_rdata   = mem[mem_addr[7:2]];
        mem_pending = 1'b0;
      end else begin
        mem_cnt = mem_cnt - 1;
      end
    end else if (IMemReq) begin
      mem_pending = 1'b1;
      mem_cnt     = lat;
      mem_addr    = IMemAddr;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h2000_0000 | 32'(i);
    mem[0]  = 32'h8C01_0004;  // LW
    mem[1]  = 32'h2002_0005;  // ADDI
    mem[2]  = 32'h0022_1820;  // R-type add
    mem[3]  = 32'h2403_0001;  // old-path word at 0xC
    mem[16] = 32'hAC01_0010;  // SW at 0x40
    mem[32] = 32'h1020_0008;  // BEQZ at 0x80
    mem[63] = 32'h2404_00FF;  // word at 0xFFFFFFFC

    rst_n = 1'b0; StallD = 1'b0; PCSrcD = 1'b0; PCBranchD = '0;
    repeat (2) step();
    chk("rst_req",   32'(IMemReq), 32'd0);
    chk("rst_addr",  IMemAddr,     32'h0);
    chk("rst_instr", InstrD,       32'h0);
    chk("rst_pcp4",  PCPlus4D,     32'h0);
    chk("rst_valid", 32'(ValidD),  32'd0);
    rst_n = 1'b1;

    // Latency 1: LW then ADDI
    step();  // 1
    chk("f0_req",  32'(IMemReq), 32'd1);
    chk("f0_addr", IMemAddr,     32'h0);
    chk("f0_vld",  32'(ValidD),  32'd0);
    step();  // 2
    chk("f0_vld_lo", 32'(ValidD), 32'd0);
    step();  // 3
    chk("f0_vld_hi", 32'(ValidD), 32'd1);
    chk("f0_op",     32'(OpD),    32'(OP_LW));
    chk("f0_pcp4",   PCPlus4D,    32'h4);
    chk("f1_addr",   IMemAddr,    32'h4);
    chk("f1_req",    32'(IMemReq), 32'd1);
    step();  // 4
    chk("f0_bubble", 32'(ValidD), 32'd0);
    step();  // 5
    chk("f1_op",    32'(OpD),    32'(OP_ADDI));
    chk("f1_funct", 32'(FunctD), 32'h05);
    chk("f1_pcp4",  PCPlus4D,    32'h8);
    chk("f1_vld",   32'(ValidD), 32'd1);
    chk("f2_addr",  IMemAddr,    32'h8);
    StallD = 1'b1;

    // Stall across the response at 0x8
    step();  // 6
    step();  // 7
    chk("st_instr", InstrD,       32'h2002_0005);
    chk("st_vld",   32'(ValidD),  32'd1);
    chk("st_req",   32'(IMemReq), 32'd0);
    step();  // 8
    chk("st_instr2", InstrD,   32'h2002_0005);
    chk("st_pcp4",   PCPlus4D, 32'h8);
    StallD = 1'b0;
    lat = 3;
    step();  // 9
    chk("hb_instr", InstrD,       32'h0022_1820);
    chk("hb_pcp4",  PCPlus4D,     32'hC);
    chk("hb_vld",   32'(ValidD),  32'd1);
    chk("hb_addr",  IMemAddr,     32'hC);
    chk("hb_req",   32'(IMemReq), 32'd1);

    // Redirect to 0x40 while WAIT, latency 3
    step();  // 10
    PCSrcD = 1'b1; PCBranchD = 32'h40;
    step();  // 11
    PCSrcD = 1'b0;
    chk("rd_vld", 32'(ValidD),  32'd0);
    chk("rd_req", 32'(IMemReq), 32'd0);
    step();  // 12
    chk("rd_drop_vld", 32'(ValidD), 32'd0);
    step();  // 13
    chk("rd_addr",    IMemAddr,     32'h40);
    chk("rd_req2",    32'(IMemReq), 32'd1);
    chk("rd_vld2",    32'(ValidD),  32'd0);
    repeat (3) step();  // 16
    chk("rd_noold_vld",   32'(ValidD), 32'd0);
    chk("rd_noold_instr", InstrD,      32'h0022_1820);
    step();  // 17
    chk("rd_instr", InstrD,      32'hAC01_0010);
    chk("rd_op",    32'(OpD),    32'(OP_SW));
    chk("rd_pcp4",  PCPlus4D,    32'h44);
    chk("rd_vld3",  32'(ValidD), 32'd1);

    // Redirect in the same cycle as the response; target low bits forced to 0
    repeat (3) step();  // 20
    PCSrcD = 1'b1; PCBranchD = 32'h83; lat = 1;
    step();  // 21
    PCSrcD = 1'b0;
    chk("sc_addr",  IMemAddr,     32'h80);
    chk("sc_req",   32'(IMemReq), 32'd1);
    chk("sc_vld",   32'(ValidD),  32'd0);
    chk("sc_instr", InstrD,       32'hAC01_0010);
    step();  // 22
    lat = 3;
    step();  // 23
    chk("sc_instr2", InstrD,      32'h1020_0008);
    chk("sc_op",     32'(OpD),    32'(OP_BEQZ));
    chk("sc_pcp4",   PCPlus4D,    32'h84);
    chk("sc_vld2",   32'(ValidD), 32'd1);
    chk("sc_addr2",  IMemAddr,    32'h84);

    // Reset mid-WAIT, stale response right after release
    step();  // 24
    rst_n = 1'b0; mem_pending = 1'b0; mem_valid = 1'b0;
    step();  // 25
    chk("mr_req",   32'(IMemReq), 32'd0);
    chk("mr_addr",  IMemAddr,     32'h0);
    chk("mr_instr", InstrD,       32'h0);
    chk("mr_vld",   32'(ValidD),  32'd0);
    rst_n = 1'b1; extra_valid = 1'b1; lat = 1;
    step();  // 26
    extra_valid = 1'b0;
    chk("mr_req1",  32'(IMemReq), 32'd1);
    chk("mr_addr1", IMemAddr,     32'h0);
    chk("mr_vld1",  32'(ValidD),  32'd0);
    step();  // 27
    chk("mr_stale_vld",   32'(ValidD), 32'd0);
    chk("mr_stale_instr", InstrD,      32'h0);
    step();  // 28
    chk("mr_instr2", InstrD,       32'h8C01_0004);
    chk("mr_pcp4",   PCPlus4D,     32'h4);
    chk("mr_vld2",   32'(ValidD),  32'd1);
    chk("mr_addr2",  IMemAddr,     32'h4);

    // Redirect from REQ to the top word; PC+4 wraps to 0
    PCSrcD = 1'b1; PCBranchD = 32'hFFFF_FFFC;
    step();  // 29
    PCSrcD = 1'b0;
    chk("wr_req", 32'(IMemReq), 32'd0);
    chk("wr_vld", 32'(ValidD),  32'd0);
    step();  // 30
    chk("wr_addr", IMemAddr,     32'hFFFF_FFFC);
    chk("wr_req2", 32'(IMemReq), 32'd1);
    step();  // 31
    step();  // 32
    chk("wr_instr", InstrD,      32'h2404_00FF);
    chk("wr_pcp4",  PCPlus4D,    32'h0);
    chk("wr_vld",   32'(ValidD), 32'd1);
    chk("wr_addr2", IMemAddr,    32'h0);

`ifdef IFETCH_PERF_EN
    begin
      int nval;
      rst_n = 1'b0; mem_pending = 1'b0; mem_valid = 1'b0; lat = 4;
      step();
      chk("pf_rst", FetchStallCnt, 32'h0);
      rst_n = 1'b1;
      nval = 0;
      for (int i = 0; i < 200 && nval < 3; i++) begin
        step();
        if (ValidD) nval++;
      end
      chk("pf_done", 32'(nval), 32'd3);
      chk("pf_cnt",  FetchStallCnt, 32'd12);
      force dut.perf_cnt_q = 32'hFFFF_FFFE;
      step();
      release dut.perf_cnt_q;
      repeat (6) step();
      chk("pf_sat", FetchStallCnt, 32'hFFFF_FFFF);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
